// File: rtl/dmem_responder.sv
// Responder for the core's M-stage data port: byte-enabled word RAM, LED register
// and free-running cycle counter behind a programmable wait-state FSM.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        flush_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [15:0] led_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  localparam logic [31:0] LedAddr = 32'h1FAF_F000;
  localparam logic [31:0] CntAddr = 32'h1FAF_E000;

  stateT       state, stateNext;
  logic [31:2] addrQ;
  logic [3:0]  wenQ;
  logic [31:0] wdataQ;
  logic [2:0]  waitCnt;
  logic [31:0] ledReg;
  logic [31:0] cycleCnt;
  logic [31:0] mem [2**ADDR_W];

  logic              accept;
  logic              doAccess;
  logic              isLed, isCnt, isRam, isUnmapped;
  logic [ADDR_W-1:0] ramIdx;
  logic [31:0]       readData;
  logic              unusedAddrBits;

  // Alignment is the core's job, so the byte offset never reaches the decode.
  assign unusedAddrBits = ^addr_i[1:0];

  assign isLed      = (addrQ == LedAddr[31:2]);
  assign isCnt      = (addrQ == CntAddr[31:2]);
  assign isRam      = (addrQ[31:ADDR_W+2] == '0);
  assign isUnmapped = ~(isLed | isCnt | isRam);
  assign ramIdx     = addrQ[ADDR_W+1:2];

  assign accept   = (state == IDLE) && req_i && !flush_i;
  assign doAccess = (state == WAIT) && !flush_i && (waitCnt == 3'd0);

  always_comb begin
    stateNext = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = WAIT;
          stall_o   = 1'b1;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (flush_i)
          stateNext = IDLE;
        else if (waitCnt == 3'd0)
          stateNext = RESP;
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    readData = '0;
    if (isLed)
      readData = ledReg;
    else if (isCnt)
      readData = cycleCnt;
    else if (isRam)
      readData = mem[ramIdx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addrQ    <= '0;
      wenQ     <= '0;
      wdataQ   <= '0;
      waitCnt  <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      ledReg   <= '0;
      cycleCnt <= '0;
    end else begin
      state    <= stateNext;
      cycleCnt <= cycleCnt + 32'd1;
      err_o    <= doAccess && isUnmapped;
      if (accept) begin
        addrQ   <= addr_i[31:2];
        wenQ    <= wen_i;
        wdataQ  <= wdata_i;
        waitCnt <= 3'(LATENCY);
      end else if (state == WAIT && waitCnt != 3'd0) begin
        waitCnt <= waitCnt - 3'd1;
      end
      // Writes also return the pre-write contents, so the read mux is sampled unconditionally.
      if (doAccess) begin
        rdata_o <= readData;
        if (isLed) begin
          for (int b = 0; b < 4; b++)
            if (wenQ[b]) ledReg[8*b +: 8] <= wdataQ[8*b +: 8];
        end
      end
    end
  end

  // RAM has no reset; a reset mid-access simply never reaches the write edge.
  always_ff @(posedge clk) begin
    if (doAccess && isRam) begin
      for (int b = 0; b < 4; b++)
        if (wenQ[b]) mem[ramIdx][8*b +: 8] <= wdataQ[8*b +: 8];
    end
  end

  assign led_o = ledReg[15:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 0, 1 and 3
// driven from a vector table plus hand sequences for flush, MMIO counter and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqI   [3];
  logic        flushI [3];
  logic [3:0]  wenI   [3];
  logic [31:0] addrI  [3];
  logic [31:0] wdataI [3];
  logic [31:0] rdataO [3];
  logic        stallO [3];
  logic        errO   [3];
  logic [15:0] ledO   [3];

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int Lat = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    dmem_responder #(.ADDR_W(10), .LATENCY(Lat)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (reqI[g]),
      .flush_i (flushI[g]),
      .wen_i   (wenI[g]),
      .addr_i  (addrI[g]),
      .wdata_i (wdataI[g]),
      .rdata_o (rdataO[g]),
      .stall_o (stallO[g]),
      .err_o   (errO[g]),
      .led_o   (ledO[g])
    );
  end

  typedef struct {
    int          dut;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chkData;
    logic [31:0] expData;
    logic        expErr;
    logic [15:0] expLed;
  } vecT;

  vecT vecs [16];

  function automatic int latOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a request at a falling edge and stays until the first unstalled cycle (RESP).
  task automatic applyStimulus(input int d, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, output int stallCycles);
    @(negedge clk);
    reqI[d]   = 1'b1;
    wenI[d]   = wen;
    addrI[d]  = addr;
    wdataI[d] = wdata;
    #1;
    stallCycles = 0;
    while (stallO[d] === 1'b1 && stallCycles < 40) begin
      stallCycles++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input int idx, input int stallCycles);
    vecT v;
    v = vecs[idx];
    compare($sformatf("vec%0d stall", idx), 32'(stallCycles), 32'(latOf(v.dut) + 2));
    if (v.chkData)
      compare($sformatf("vec%0d rdata", idx), rdataO[v.dut], v.expData);
    compare($sformatf("vec%0d err", idx), 32'(errO[v.dut]), 32'(v.expErr));
    compare($sformatf("vec%0d led", idx), 32'(ledO[v.dut]), 32'(v.expLed));
    reqI[v.dut] = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] c1;

    vecs[0]  = '{1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 16'h0};
    vecs[1]  = '{1, 4'h0,    32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF, 1'b0, 16'h0};
    vecs[2]  = '{0, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 16'h0};
    vecs[3]  = '{0, 4'b0100, 32'h0000_0010, 32'h00AA_0000, 1, 32'hDEAD_BEEF, 1'b0, 16'h0};
    vecs[4]  = '{0, 4'h0,    32'h0000_0010, 32'h0,         1, 32'hDEAA_BEEF, 1'b0, 16'h0};
    vecs[5]  = '{0, 4'hF,    32'h0000_0000, 32'h1122_3344, 0, 32'h0,         1'b0, 16'h0};
    vecs[6]  = '{0, 4'hF,    32'h1FAF_F000, 32'h0000_A5A5, 1, 32'h0,         1'b0, 16'hA5A5};
    vecs[7]  = '{0, 4'b1000, 32'h1FAF_F000, 32'hFF00_0000, 1, 32'h0000_A5A5, 1'b0, 16'hA5A5};
    vecs[8]  = '{0, 4'h0,    32'h1FAF_F003, 32'h0,         1, 32'hFF00_A5A5, 1'b0, 16'hA5A5};
    vecs[9]  = '{0, 4'hF,    32'h1FAF_E000, 32'hFFFF_FFFF, 0, 32'h0,         1'b0, 16'hA5A5};
    vecs[10] = '{0, 4'h0,    32'h0000_1000, 32'h0,         1, 32'h0,         1'b1, 16'hA5A5};
    vecs[11] = '{2, 4'hF,    32'h0000_0020, 32'h0,         0, 32'h0,         1'b0, 16'h0};
    vecs[12] = '{2, 4'h0,    32'h0000_0020, 32'h0,         1, 32'h0,         1'b0, 16'h0};
    vecs[13] = '{2, 4'hF,    32'h0000_0040, 32'hCAFE_F00D, 0, 32'h0,         1'b0, 16'h0};
    vecs[14] = '{2, 4'hF,    32'h1FAF_F000, 32'h0000_1234, 1, 32'h0,         1'b0, 16'h1234};
    vecs[15] = '{2, 4'h0,    32'h0000_0040, 32'h0,         1, 32'hCAFE_F00D, 1'b0, 16'h1234};

    for (int d = 0; d < 3; d++) begin
      reqI[d] = 1'b0; flushI[d] = 1'b0; wenI[d] = '0; addrI[d] = '0; wdataI[d] = '0;
    end

    #23;
    for (int d = 0; d < 3; d++) begin
      compare($sformatf("reset dut%0d rdata", d), rdataO[d], 32'h0);
      compare($sformatf("reset dut%0d stall/err", d), {30'h0, stallO[d], errO[d]}, 32'h0);
      compare($sformatf("reset dut%0d led", d), 32'(ledO[d]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].dut, vecs[i].wen, vecs[i].addr, vecs[i].wdata, n);
      checkOutput(i, n);
    end

    // Back-to-back cycle counter reads are exactly three edges apart at LATENCY 0.
    applyStimulus(0, 4'h0, 32'h1FAF_E000, 32'h0, n);
    c1 = rdataO[0];
    reqI[0] = 1'b0;
    applyStimulus(0, 4'h0, 32'h1FAF_E000, 32'h0, n);
    compare("counter delta", rdataO[0] - c1, 32'd3);
    reqI[0] = 1'b0;

    // Unmapped write and read: one-cycle err pulse each, read of zero, RAM word 0 untouched.
    applyStimulus(0, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF, n);
    compare("unmapped wr err", 32'(errO[0]), 32'h1);
    reqI[0] = 1'b0;
    @(negedge clk);
    compare("unmapped wr err drop", 32'(errO[0]), 32'h0);
    applyStimulus(0, 4'h0, 32'h8000_0000, 32'h0, n);
    compare("unmapped rd err", 32'(errO[0]), 32'h1);
    compare("unmapped rd data", rdataO[0], 32'h0);
    reqI[0] = 1'b0;
    @(negedge clk);
    compare("unmapped rd err drop", 32'(errO[0]), 32'h0);
    applyStimulus(0, 4'h0, 32'h0000_0000, 32'h0, n);
    compare("ram word0 intact", rdataO[0], 32'h1122_3344);
    reqI[0] = 1'b0;

    // Flush in the second WAIT cycle at LATENCY 3 drops the write.
    @(negedge clk);
    reqI[2] = 1'b1; wenI[2] = 4'hF; addrI[2] = 32'h0000_0020; wdataI[2] = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    flushI[2] = 1'b1;
    #1;
    compare("flush cycle stall", 32'(stallO[2]), 32'h1);
    @(negedge clk);
    compare("after flush stall", 32'(stallO[2]), 32'h0);
    compare("after flush rdata", rdataO[2], 32'hCAFE_F00D);
    reqI[2] = 1'b0; flushI[2] = 1'b0;
    applyStimulus(2, 4'h0, 32'h0000_0020, 32'h0, n);
    compare("after flush stall len", 32'(n), 32'd5);
    compare("after flush read 0x20", rdataO[2], 32'h0);
    reqI[2] = 1'b0;
    applyStimulus(2, 4'h0, 32'h0000_0040, 32'h0, n);
    compare("pre-reset read 0x40", rdataO[2], 32'hCAFE_F00D);
    reqI[2] = 1'b0;

    // Asynchronous reset mid-WAIT, off the clock grid; the pending write must be lost.
    @(negedge clk);
    reqI[2] = 1'b1; wenI[2] = 4'hF; addrI[2] = 32'h0000_0040; wdataI[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    #3;
    rst = 1'b1;
    reqI[2] = 1'b0;
    #1;
    compare("async rst stall", 32'(stallO[2]), 32'h0);
    compare("async rst rdata", rdataO[2], 32'h0);
    compare("async rst led", 32'(ledO[2]), 32'h0);
    #12;
    rst = 1'b0;
    applyStimulus(2, 4'h0, 32'h0000_0040, 32'h0, n);
    compare("post-reset stall len", 32'(n), 32'd5);
    compare("post-reset read 0x40", rdataO[2], 32'hCAFE_F00D);
    reqI[2] = 1'b0;

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
